// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side controller for the iceFUN 16-bit asynchronous SRAM.
//
// Accepts single-word read/write requests over a valid/ready handshake and
// sequences IDLE -> SETUP -> ACCESS -> HOLD -> TURN -> IDLE. Every SRAM pin,
// req_ready, rsp_valid and rsp_rdata comes straight from a flop.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_be        request payload, be[0]=low byte, be[1]=high byte
//   rsp_valid, rsp_rdata     one-cycle completion pulse, read data (masked by be)
//   sram_addr, sram_dq_o,
//   sram_dq_oe, sram_dq_i    address and split data bus (pad tristate is external)
//   sram_we_n, sram_oe_n,
//   sram_ce_n, sram_lb_n,
//   sram_ub_n, sram_ce2      chip strobes in the device's pin naming
//
// Optional build macro SRAM_CTRL_STATS_EN adds rd_count/wr_count outputs,
// 16-bit wrapping counts of completed reads and writes.

module sram_ctrl #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic              sram_ce2
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned LANE_W = DATA_W / 2;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
  end
  if (TURN_CYCLES > 15) begin : g_bad_turn
    $error("sram_ctrl: TURN_CYCLES must be in 0..15");
  end
  if (DATA_W != 2 * LANE_W) begin : g_bad_data
    $error("sram_ctrl: DATA_W must split into two byte lanes");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_ce_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_ce2   <= 1'b0;
`ifdef SRAM_CTRL_STATS_EN
      rd_count   <= '0;
      wr_count   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            // Outputs for SETUP are loaded on the accept edge itself.
            req_ready <= 1'b0;
            we_q      <= req_we;
            be_q      <= req_be;
            sram_addr <= req_addr;
            sram_ce_n <= 1'b0;
            sram_ce2  <= 1'b1;
            sram_lb_n <= ~req_be[0];
            sram_ub_n <= ~req_be[1];
            if (req_we) begin
              sram_dq_o  <= req_wdata;
              sram_dq_oe <= 1'b1;
            end
            state <= S_SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          wait_cnt <= 4'(WAIT_CYCLES - 1);
          if (we_q) begin
            // A write with no byte enabled completes without a write strobe.
            sram_we_n <= ~(|be_q);
          end else begin
            sram_oe_n <= 1'b0;
          end
          state <= S_ACCESS;
        end

        S_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            rsp_valid <= 1'b1;
            if (!we_q) begin
              rsp_rdata <= {{LANE_W{be_q[1]}} & sram_dq_i[DATA_W-1:LANE_W],
                            {LANE_W{be_q[0]}} & sram_dq_i[LANE_W-1:0]};
            end
`ifdef SRAM_CTRL_STATS_EN
            if (we_q) wr_count <= wr_count + 16'd1;
            else      rd_count <= rd_count + 16'd1;
`endif
            state <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_HOLD: begin
          sram_ce_n  <= 1'b1;
          sram_ce2   <= 1'b0;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (TURN_CYCLES == 0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= 4'(TURN_CYCLES - 1);
            state    <= S_TURN;
          end
        end

        S_TURN: begin
          if (wait_cnt == 4'd0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl with a behavioural SRAM.
// Expected read data is pushed to a scoreboard queue when a request is
// driven and compared when rsp_valid pulses; per-request strobe traces are
// compared against windows derived from WAIT_CYCLES/TURN_CYCLES.

module tb_sram_ctrl;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int W = 2;
  localparam int T = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_i;
  logic          sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n, sram_ce2;
`ifdef SRAM_CTRL_STATS_EN
  logic [15:0]   rd_count, wr_count;
`endif

  sram_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(W),
    .TURN_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n),
    .sram_ce2(sram_ce2)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: 64 words aliased on addr[5:0]; disabled read lanes
  // drive junk so the controller's lane masking is visible.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic [5:0]    idx;
  assign idx = sram_addr[5:0];

  always_comb begin
    sram_dq_i = 16'hDEAD;
    if (!sram_ce_n && sram_ce2 && !sram_oe_n) begin
      sram_dq_i[7:0]  = sram_lb_n ? 8'hC3 : mem[idx][7:0];
      sram_dq_i[15:8] = sram_ub_n ? 8'h3C : mem[idx][15:8];
    end
  end

  always @(posedge clk) begin
    if (!sram_ce_n && sram_ce2 && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[idx][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[idx][15:8] <= sram_dq_o[15:8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_rdata = '0;
  int n_rd = 0;
  int n_wr = 0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(sb.pop_front()));
      end
    end
  end

  function automatic logic [7:0] span(input int lo, input int hi);
    logic [7:0] m = '0;
    for (int i = lo; i <= hi; i++) if (i >= 0 && i < 8) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_expected(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [1:0] be);
    logic [DW-1:0] e;
    if (we) begin
      sb.push_back(last_rdata);
      if (be[0]) ref_mem[addr[5:0]][7:0]  = wdata[7:0];
      if (be[1]) ref_mem[addr[5:0]][15:8] = wdata[15:8];
      n_wr++;
    end else begin
      e = ref_mem[addr[5:0]];
      e = {be[1] ? e[15:8] : 8'h00, be[0] ? e[7:0] : 8'h00};
      sb.push_back(e);
      last_rdata = e;
      n_rd++;
    end
  endtask

  // Called at a negedge; issues one request and traces cycles 1..7 after accept.
  task automatic do_req(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [1:0] be);
    int waited = 0;
    logic [7:0] we_lo = '0, oe_lo = '0, oe_t = '0, ce_lo = '0, rv = '0, rr = '0;
    logic cont = 1'b0;
    logic [7:0] acc;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    push_expected(we, addr, wdata, be);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        check({tag, "_addr"}, 32'(sram_addr), 32'(addr));
        check({tag, "_lanes"}, {30'd0, sram_ub_n, sram_lb_n}, {30'd0, ~be});
        if (we) check({tag, "_dq_o"}, 32'(sram_dq_o), 32'(wdata));
      end
      we_lo[k] = !sram_we_n;
      oe_lo[k] = !sram_oe_n;
      oe_t[k]  = sram_dq_oe;
      ce_lo[k] = !sram_ce_n && sram_ce2;
      rv[k]    = rsp_valid;
      rr[k]    = req_ready;
      if (sram_dq_oe && !sram_oe_n) cont = 1'b1;
    end
    acc = span(2, 1 + W);
    check({tag, "_we_n"},   32'(we_lo), 32'((we && be != 2'b00) ? acc : 8'h00));
    check({tag, "_oe_n"},   32'(oe_lo), 32'(we ? 8'h00 : acc));
    check({tag, "_dq_oe"},  32'(oe_t),  32'(we ? span(1, 2 + W) : 8'h00));
    check({tag, "_ce"},     32'(ce_lo), 32'(span(1, 2 + W)));
    check({tag, "_rsp_t"},  32'(rv),    32'(span(2 + W, 2 + W)));
    check({tag, "_ready_t"},32'(rr),    32'(span(3 + W + T, 7)));
    check({tag, "_contention"}, 32'(cont), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc [4];
    int n_acc;
    int waited;
    logic saw_rsp;

    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'(i * 16'h0101);
      ref_mem[i] = mem[i];
    end
    mem[16] = 16'h1234; ref_mem[16] = 16'h1234;
    mem[32] = 16'hBEEF; ref_mem[32] = 16'hBEEF;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    check("rst_pins",
          {23'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n,
           sram_ce2, sram_dq_oe, req_ready, rsp_valid},
          {23'd0, 9'b11111_0000});
    check("rst_addr_data", {sram_addr[15:0], sram_dq_o}, 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rise", 32'(req_ready), 32'd1);

    do_req("wr_top", 1'b1, 22'h3FFFFF, 16'hA55A, 2'b11);
    do_req("rd_1234", 1'b0, 22'h000010, 16'h0000, 2'b11);
    do_req("rd_be01", 1'b0, 22'h000020, 16'h0000, 2'b01);
    do_req("wr_be00", 1'b1, 22'h000010, 16'hFFFF, 2'b00);
    do_req("rd_after_be00", 1'b0, 22'h000010, 16'h0000, 2'b11);
    do_req("rd_top", 1'b0, 22'h3FFFFF, 16'h0000, 2'b11);

    // Back-to-back: req_valid held high for four accepts
    req_we = 1'b0; req_addr = 22'h000010; req_be = 2'b11; req_valid = 1'b1;
    n_acc = 0; waited = 0;
    while (n_acc < 4 && waited < 100) begin
      if (req_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        push_expected(1'b0, 22'h000010, 16'h0000, 2'b11);
      end
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    for (int i = 0; i < 3; i++)
      if (i + 1 < n_acc)
        check("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(3 + W + T));
    repeat (8) @(negedge clk);
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Reset during cycle 2 of a write
    req_we = 1'b1; req_addr = 22'h000030; req_wdata = 16'h1111; req_be = 2'b11;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("midrst_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_we_low", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pins", {28'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe},
          {28'd0, 4'b1110});
    check("midrst_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    last_rdata = '0;
    n_rd = 0;
    n_wr = 0;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("midrst_no_rsp", 32'(saw_rsp), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);

    do_req("wr_be00_postrst", 1'b1, 22'h000020, 16'h0000, 2'b00);
    do_req("wr_be10", 1'b1, 22'h3FFFFF, 16'h77CC, 2'b10);
    do_req("rd_merge", 1'b0, 22'h3FFFFF, 16'h0000, 2'b11);

`ifdef SRAM_CTRL_STATS_EN
    check("stats_wr", 32'(wr_count), 32'(n_wr));
    check("stats_rd", 32'(rd_count), 32'(n_rd));
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
